// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding, status-flag bit positions and opcode classification
// used by the ALU write-back stage.
package alu_pkg;

   typedef enum logic [3:0] {
      NOP         = 4'd0,
      MOV         = 4'd1,
      CMP         = 4'd2,
      TEST        = 4'd3,
      SHFT_L      = 4'd4,
      SHFT_R      = 4'd5,
      ADD         = 4'd6,
      ADC         = 4'd7,
      SUB         = 4'd8,
      SBB         = 4'd9,
      MUL         = 4'd10,
      AND         = 4'd11,
      OR          = 4'd12,
      XOR         = 4'd13,
      NOT         = 4'd14,
      CLEAR_FLAGS = 4'd15
   } alu_op_t;

   typedef enum logic [1:0] {
      CLS_WRITE,
      CLS_FLAGS_ONLY,
      CLS_NOP,
      CLS_CLEAR
   } op_class_t;

   localparam int unsigned FLAG_Z = 7;
   localparam int unsigned FLAG_S = 6;
   localparam int unsigned FLAG_C = 5;
   localparam int unsigned FLAG_O = 4;

   function automatic op_class_t alu_op_class(input alu_op_t op);
      case (op)
         NOP:         return CLS_NOP;
         CMP, TEST:   return CLS_FLAGS_ONLY;
         CLEAR_FLAGS: return CLS_CLEAR;
         default:     return CLS_WRITE;
      endcase
   endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry skid FIFO buffering register-file write-backs; the head entry is
// presented continuously and only advances on pop.
module wb_skid_fifo #(
   parameter int unsigned WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head_data  = mem[rd_ptr];
   assign head_valid = (count != 2'd0);

endmodule

// File: rtl/alu_writeback_stage.sv
// Registered stage after the ALU: owns the status-flags register, counts retired
// instructions and buffers write-backs. Optional macro: ALU_WB_BYPASS_EN.
module alu_writeback_stage
   import alu_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 8,
   parameter int unsigned DEST_BITS = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_opcode,
   input  logic [WORD_SIZE-1:0] in_result,
   input  logic [7:0]           in_flags,
   input  logic [DEST_BITS-1:0] in_dest,
   output logic                 wb_valid,
   input  logic                 wb_ready,
   output logic [WORD_SIZE-1:0] wb_data,
   output logic [DEST_BITS-1:0] wb_dest,
   output logic [7:0]           status_flags,
   output logic [15:0]          retire_count
);

   localparam int unsigned ENTRY_W = WORD_SIZE + DEST_BITS;

   alu_op_t                op;
   op_class_t              cls;
   logic                   accept;
   logic                   is_write;
   logic                   push;
   logic                   pop;
   logic                   head_valid;
   logic [ENTRY_W-1:0]     head_data;
   logic [1:0]             count;
   logic [7:0]             flags_next;
   logic                   unused_flags;

   assign op           = alu_op_t'(in_opcode);
   assign cls          = alu_op_class(op);
   assign in_ready     = (count != 2'd2);
   assign accept       = in_valid && in_ready;
   assign is_write     = accept && (cls == CLS_WRITE);
   assign unused_flags = ^in_flags[3:0];

`ifdef ALU_WB_BYPASS_EN
   // An empty FIFO lets the incoming entry drive wb_* directly; it is only
   // buffered if the register file does not take it this cycle.
   logic bypass;
   assign bypass   = is_write && (count == 2'd0);
   assign wb_valid = head_valid || bypass;
   assign push     = is_write && !(bypass && wb_ready);
   assign pop      = head_valid && wb_ready;
   assign {wb_data, wb_dest} = (bypass && !head_valid) ? {in_result, in_dest} : head_data;
`else
   assign wb_valid = head_valid;
   assign push     = is_write;
   assign pop      = head_valid && wb_ready;
   assign {wb_data, wb_dest} = head_data;
`endif

   wb_skid_fifo #(
      .WIDTH(ENTRY_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_data  ({in_result, in_dest}),
      .pop        (pop),
      .head_data  (head_data),
      .head_valid (head_valid),
      .count      (count)
   );

   always_comb begin
      flags_next = status_flags;
      if (accept) begin
         case (op)
            ADD, ADC, SUB, SBB, MUL, CMP: begin
               flags_next[FLAG_Z] = in_flags[FLAG_Z];
               flags_next[FLAG_S] = in_flags[FLAG_S];
               flags_next[FLAG_C] = in_flags[FLAG_C];
               flags_next[FLAG_O] = in_flags[FLAG_O];
            end
            SHFT_L, SHFT_R: begin
               flags_next[FLAG_Z] = in_flags[FLAG_Z];
               flags_next[FLAG_S] = in_flags[FLAG_S];
               flags_next[FLAG_C] = in_flags[FLAG_C];
               flags_next[FLAG_O] = 1'b0;
            end
            AND, OR, XOR, NOT, TEST: begin
               flags_next[FLAG_Z] = in_flags[FLAG_Z];
               flags_next[FLAG_S] = in_flags[FLAG_S];
               flags_next[FLAG_C] = 1'b0;
               flags_next[FLAG_O] = 1'b0;
            end
            CLEAR_FLAGS: flags_next = '0;
            default:     flags_next = status_flags;
         endcase
      end
      flags_next[3:0] = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status_flags <= '0;
         retire_count <= '0;
      end else begin
         status_flags <= flags_next;
         if (accept && (cls != CLS_NOP))
            retire_count <= retire_count + 16'd1;
      end
   end

endmodule
